// File: rtl/spi_flash_resp.sv
// SPI mode-0 slave emulating the N25Q read subset (READ/RDID/RDSR) from a byte memory.
// SPI pins are oversampled and edge-detected in the sys_clk domain.
module spi_flash_resp #(
  parameter int unsigned ADDR_W      = 24,
  parameter logic [23:0] JEDEC_ID    = 24'h20BA18,
  parameter logic [7:0]  STATUS      = 8'h00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_ID, S_STAT, S_IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  logic              clk_s, cs_s, mosi_s;
  logic              rise, fall, cs_rise, cs_fall;

  state_e            state_q, state_d;
  logic              clk_prev_q, clk_prev_d;
  logic              cs_prev_q, cs_prev_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        shift_in_q, shift_in_d;
  logic [23:0]       addr_q, addr_d;
  logic [7:0]        shift_out_q, shift_out_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              rd_pend_q, rd_pend_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              cmd_err_q, cmd_err_d;

  logic [7:0]        cmd_nxt;
  logic [23:0]       addr_nxt;
  logic [7:0]        out_byte;

  // Synchronizer chains are pure data pipelines and keep running through reset
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end

  always_ff @(posedge sys_clk) begin
    clk_sync_q  <= clk_sync_d;
    cs_sync_q   <= cs_sync_d;
    mosi_sync_q <= mosi_sync_d;
  end

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];

  // A deselected (or deselecting) chip masks every spi_clk edge
  assign rise    = clk_s & ~clk_prev_q & ~cs_s;
  assign fall    = ~clk_s & clk_prev_q & ~cs_s;
  assign cs_rise = cs_s & ~cs_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;

  always_comb begin
    state_d     = state_q;
    clk_prev_d  = clk_s;
    cs_prev_d   = cs_s;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_in_d  = shift_in_q;
    addr_d      = addr_q;
    shift_out_d = shift_out_q;
    tx_byte_d   = tx_byte_q;
    rd_pend_d   = mem_rd_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    busy_d      = ~cs_s;
    cmd_err_d   = 1'b0;
    cmd_nxt     = {shift_in_q[6:0], mosi_s};
    addr_nxt    = {addr_q[22:0], mosi_s};
    out_byte    = 8'h00;

    // Memory data arrives one cycle after the strobe
    if (rd_pend_q) tx_byte_d = mem_rdata;

    if (cs_rise) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      shift_in_d = 8'h00;
      addr_d     = 24'h000000;
      oe_d       = 1'b0;
      miso_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d    = S_CMD;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
          end else if (!cs_s) begin
            state_d = S_IGNORE;
          end
        end
        S_CMD: begin
          if (rise) begin
            shift_in_d = cmd_nxt;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = 2'd0;
              unique case (cmd_nxt)
                OP_READ: state_d = S_ADDR;
                OP_RDID: state_d = S_ID;
                OP_RDSR: state_d = S_STAT;
                default: begin
                  state_d   = S_IGNORE;
                  cmd_err_d = 1'b1;
                end
              endcase
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr_d    = addr_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd2) begin
                mem_addr_d = addr_nxt[ADDR_W-1:0];
                mem_rd_d   = 1'b1;
                byte_cnt_d = 2'd0;
                state_d    = S_DATA;
              end
            end
          end
        end
        S_DATA, S_ID, S_STAT: begin
          if (fall) begin
            oe_d      = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (state_q == S_DATA) begin
                out_byte   = tx_byte_q;
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                mem_rd_d   = 1'b1;
              end else if (state_q == S_ID) begin
                unique case (byte_cnt_q)
                  2'd0:    out_byte = JEDEC_ID[23:16];
                  2'd1:    out_byte = JEDEC_ID[15:8];
                  2'd2:    out_byte = JEDEC_ID[7:0];
                  default: out_byte = 8'h00;
                endcase
                if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
              end else begin
                out_byte = STATUS;
              end
              miso_d      = out_byte[7];
              shift_out_d = {out_byte[6:0], 1'b0};
            end else begin
              miso_d      = shift_out_q[7];
              shift_out_d = {shift_out_q[6:0], 1'b0};
            end
          end
        end
        S_IGNORE: begin
          oe_d   = 1'b0;
          miso_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // cs_prev resets low so a cs held low through reset is not seen as a new select
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      clk_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      shift_in_q  <= 8'h00;
      addr_q      <= 24'h000000;
      shift_out_q <= 8'h00;
      tx_byte_q   <= 8'h00;
      rd_pend_q   <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_prev_q  <= clk_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_in_q  <= shift_in_d;
      addr_q      <= addr_d;
      shift_out_q <= shift_out_d;
      tx_byte_q   <= tx_byte_d;
      rd_pend_q   <= rd_pend_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = busy_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: doc/spi_flash_resp.md
Name: spi_flash_resp

Overview:
- Synthesizable SPI mode-0 slave that answers the SoC SPI master on chip select 0.
- Emulates the read subset of the N25Q serial flash command set: READ 0x03, RDID 0x9F and RDSR 0x05.
- Sourced from an external synchronous byte memory, for boot images on FPGA/emulation builds where no flash model exists.
- SPI pins are oversampled in the sys_clk domain; all logic is single-clock.

Parameters:
- ADDR_W, 24, byte address width of the memory port; the SPI address is always 24 bits, truncated to ADDR_W LSBs.
- JEDEC_ID, 24'h20BA18, three RDID bytes, MSB byte sent first.
- STATUS, 8'h00, value returned repeatedly by RDSR.
- SYNC_STAGES, 2, synchronizer depth for spi_clk/spi_cs/spi_mosi (≥2).

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- spi_clk  in  1  SPI clock from master, idle low (mode 0).
- spi_cs  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  output enable for the MISO pad.
- mem_rd  out  1  one-cycle memory read strobe.
- mem_addr  out  ADDR_W  memory byte address.
- mem_rdata  in  8  read data, valid exactly 1 sys_clk after mem_rd.
- busy  out  1  high while a transaction is selected.
- cmd_err  out  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, mem_rd=0, mem_addr=0, busy=0, cmd_err=0, state IDLE, bit counter 0.
- Synchronization and edges:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - rise/fall are detected on the synchronized spi_clk, using the synchronized spi_cs.
  - Required ratio: sys_clk ≥ 8× spi_clk.
- Sampling: spi_mosi is sampled MSB-first on rise; spi_miso is updated on fall.
- States:
  - IDLE: cs high; goes to CMD on cs falling.
  - CMD: shift 8 bits; on the 8th rise, decode:
    - 0x03 → ADDR.
    - 0x9F → ID.
    - 0x05 → STAT.
    - Otherwise → IGNORE and pulse cmd_err.
  - ADDR: shift 24 bits. On the 24th rise:
    - mem_addr ← addr[ADDR_W-1:0], pulse mem_rd.
    - Latch mem_rdata into tx_byte the next cycle.
    - Go to DATA.
  - DATA:
    - On each byte boundary fall, load tx_byte into the shifter; spi_miso = bit7.
    - The same cycle, mem_addr increments (wraps at 2^ADDR_W−1 → 0) and mem_rd pulses to prefetch the following byte.
    - Streaming is unbounded.
  - ID: shifts JEDEC_ID[23:16], [15:8], [7:0]; thereafter drives 0x00.
  - STAT: shifts STATUS repeatedly.
  - IGNORE: spi_miso_oe=0 until cs rises.
- Output enable: spi_miso_oe=1 only in DATA/ID/STAT, from the first fall after the command/address phase until cs rises. spi_miso=0 whenever oe=0.
- cs deassert (synchronized rising) at any point, mid-byte included:
  - State → IDLE; counters clear.
  - oe=0, busy=0 the following cycle.
  - No mem_rd is issued afterwards.
  - A partial command/address is discarded.
- busy = synchronized cs low.
- Simultaneous cs rise and spi_clk edge in the same cycle: cs wins; the edge is ignored.
- Reset mid-transaction: immediate return to reset values; the block resumes only at the next cs falling edge (reset while cs low → IGNORE until cs high).
- spi_clk edges while cs high are ignored.

Test Plan:
- READ at 0x000010 with memory[0x10..0x13]=A5,3C,00,FF and spi_clk=sys_clk/8 → MISO returns A5 3C 00 FF; mem_rd pulses 5 times (initial + 4 prefetches); mem_addr ends at 0x14.
- READ at 0xFFFFFE, ADDR_W=24, read 4 bytes → bytes from addresses FFFFFE, FFFFFF, 000000, 000001 in that order.
- RDID → 20 BA 18 then 00 00; RDSR for 3 bytes → 00 00 00; oe high only during the response bytes.
- Opcode 0xAB → cmd_err one-cycle pulse after the 8th rise; oe stays 0; mem_rd never asserted; next cs cycle with 0x9F works normally.
- cs raised after 12 address bits, then a fresh READ at 0x000000 → first transaction discarded, no mem_rd; second returns memory[0].
- sys_rst asserted mid-DATA with cs low → outputs at reset values next cycle, no response until cs toggles high then low; subsequent READ correct.
